// File: rtl/dram_port_arbiter_pkg.sv
// rtl/dram_port_arbiter_pkg.sv - shared lane geometry, bundle types and arbiter states
//
// Purpose: common definitions for the DRAM port arbiter and its round-robin picker.
// Contents:
//   DRAM_LANES, ADDR_W, BYTE_W  - geometry of the shared 8-lane byte port
//   lane_en_t                   - per-lane enable vector
//   lane_addr_t / lane_data_t   - per-lane byte address / byte data bundles
//   arb_state_t                 - IDLE / OWN / DRAIN ownership states

package dram_port_arbiter_pkg;

  localparam int DRAM_LANES = 8;
  localparam int ADDR_W     = 64;
  localparam int BYTE_W     = 8;

  typedef logic [DRAM_LANES-1:0]             lane_en_t;
  typedef logic [DRAM_LANES-1:0][ADDR_W-1:0] lane_addr_t;
  typedef logic [DRAM_LANES-1:0][BYTE_W-1:0] lane_data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dram_port_arbiter_rr_picker.sv
// rtl/dram_port_arbiter_rr_picker.sv - combinational round-robin priority select
//
// Purpose: pick the first active request at or after rr_ptr, wrapping past NUM_REQ-1.
// Ports:
//   req          in   NUM_REQ  request vector
//   rr_ptr       in   IDX_W    index with highest priority this round
//   any          out  1        at least one request active
//   pick_onehot  out  NUM_REQ  one-hot winner (zero when no request)
//   pick_idx     out  IDX_W    binary index of the winner

module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               any,
  output logic [NUM_REQ-1:0] pick_onehot,
  output logic [IDX_W-1:0]   pick_idx
);

  // rr_ptr never exceeds NUM_REQ-1, so a single modulo handles the wrap.
  function automatic int wrap_idx(input int base, input int offset);
    return (base + offset) % NUM_REQ;
  endfunction

  always_comb begin
    any         = 1'b0;
    pick_onehot = '0;
    pick_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[wrap_idx(int'(rr_ptr), i)]) begin
        any                                        = 1'b1;
        pick_onehot[wrap_idx(int'(rr_ptr), i)]     = 1'b1;
        pick_idx                                   = IDX_W'(wrap_idx(int'(rr_ptr), i));
      end
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - round-robin owner arbiter for one shared 8-lane DRAM port
//
// Purpose: grants one serializer engine at a time ownership of the DRAM port for a whole
// multi-cycle transaction, muxes that engine's lane bundle onto DRAM, limits reads in
// flight, and routes read responses back to the engine that issued them.
// Ports:
//   clk            in   1                  system clock
//   reset          in   1                  asynchronous active-low reset
//   req            in   NUM_REQ            ownership request, held for the transaction
//   req_en         in   NUM_REQ x 8        per-engine lane enables
//   req_addr       in   NUM_REQ x 8 x 64   per-engine lane byte addresses
//   req_rdwr       in   NUM_REQ            1 = write, 0 = read
//   req_data       in   NUM_REQ x 8 x 8    per-engine lane write bytes
//   gnt            out  NUM_REQ            one-hot ownership (registered)
//   rsp_valid      out  NUM_REQ            read data valid for the issuing engine
//   rsp_data       out  8 x 8              read bytes, broadcast
//   dram_en        out  8                  lane enables to DRAM
//   dram_addr      out  8 x 64             lane addresses to DRAM
//   dram_rdwr      out  1                  1 = write, 0 = read
//   dram_data      out  8 x 8              write bytes to DRAM
//   dram_data_out  in   8 x 8              read bytes from DRAM
//   dram_valid     in   1                  read data valid from DRAM
//   busy           out  1                  port owned or reads outstanding

module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_REQ-1:0]                           req,
  input  logic [NUM_REQ-1:0][DRAM_LANES-1:0]           req_en,
  input  logic [NUM_REQ-1:0][DRAM_LANES-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]                           req_rdwr,
  input  logic [NUM_REQ-1:0][DRAM_LANES-1:0][BYTE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]                           gnt,
  output logic [NUM_REQ-1:0]                           rsp_valid,
  output lane_data_t                                   rsp_data,
  output lane_en_t                                     dram_en,
  output lane_addr_t                                   dram_addr,
  output logic                                         dram_rdwr,
  output lane_data_t                                   dram_data,
  input  lane_data_t                                   dram_data_out,
  input  logic                                         dram_valid,
  output logic                                         busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;

  logic               pick_any;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;

  logic read_full;
  logic read_issue;
  logic rsp_live;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req         (req),
    .rr_ptr      (rr_ptr_q),
    .any         (pick_any),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx)
  );

  assign read_full = (outstanding_q == MAX_CNT);

  // Owner bundle mux. Lane enables only pass in OWN, so other engines' enables and the
  // turnaround/drain cycles never reach DRAM. A read is held off (en forced low) while the
  // in-flight count is at its limit; the engine keeps presenting it until a slot frees.
  always_comb begin
    dram_en   = '0;
    dram_rdwr = 1'b0;
    dram_addr = req_addr[owner_q];
    dram_data = req_data[owner_q];
    if (state_q == OWN) begin
      dram_rdwr = req_rdwr[owner_q];
      dram_en   = req_en[owner_q];
      if (!req_rdwr[owner_q] && read_full) begin
        dram_en = '0;
      end
    end
  end

  assign read_issue = (state_q == OWN) && (dram_en != '0) && !dram_rdwr;

  // A return with nothing in flight is stray and is neither routed nor counted.
  assign rsp_live = dram_valid && (outstanding_q != '0);

  always_comb begin
    rsp_valid = '0;
    if (rsp_live) begin
      rsp_valid[owner_q] = 1'b1;
    end
  end

  assign rsp_data = dram_data_out;

  always_comb begin
    outstanding_d = outstanding_q;
    case ({read_issue, rsp_live})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Next-state logic. owner_q is kept through DRAIN so late responses still find
  // the engine that issued them; it is only replaced by the next grant.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = OWN;
          gnt_d   = pick_onehot;
          owner_d = pick_idx;
        end
      end
      OWN: begin
        if (!req[owner_q]) begin
          gnt_d    = '0;
          rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
          // Counting the read issued this same cycle keeps its response routable.
          state_d  = (outstanding_d != '0) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (outstanding_d == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      gnt_q         <= '0;
      rr_ptr_q      <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      gnt_q         <= gnt_d;
      rr_ptr_q      <= rr_ptr_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - self-checking bench for dram_port_arbiter

module tb_dram_port_arbiter;
  import dram_port_arbiter_pkg::*;

  localparam int NR = 4;

  logic                            clk;
  logic                            reset;
  logic [NR-1:0]                   req;
  logic [NR-1:0][7:0]              req_en;
  logic [NR-1:0][7:0][63:0]        req_addr;
  logic [NR-1:0]                   req_rdwr;
  logic [NR-1:0][7:0][7:0]         req_data;
  logic [NR-1:0]                   gnt;
  logic [NR-1:0]                   rsp_valid;
  lane_data_t                      rsp_data;
  lane_en_t                        dram_en;
  lane_addr_t                      dram_addr;
  logic                            dram_rdwr;
  lane_data_t                      dram_data;
  lane_data_t                      dram_data_out;
  logic                            dram_valid;
  logic                            busy;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        obs_q[$];
  lane_data_t exp_rsp_q[$];
  logic [7:0] mem [logic [63:0]];

  int n_vec = 0;
  int n_err = 0;

  dram_port_arbiter #(
    .NUM_REQ         (NR),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_en        (req_en),
    .req_addr      (req_addr),
    .req_rdwr      (req_rdwr),
    .req_data      (req_data),
    .gnt           (gnt),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .dram_en       (dram_en),
    .dram_addr     (dram_addr),
    .dram_rdwr     (dram_rdwr),
    .dram_data     (dram_data),
    .dram_data_out (dram_data_out),
    .dram_valid    (dram_valid),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DRAM write side: commit every enabled write lane, mid-cycle when the bus is stable.
  always @(negedge clk) begin
    if (reset === 1'b1 && dram_rdwr === 1'b1) begin
      for (int l = 0; l < 8; l++) begin
        if (dram_en[l] === 1'b1) begin
          obs_q.push_back('{addr: dram_addr[l], data: dram_data[l]});
          mem[dram_addr[l]] = dram_data[l];
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req           = '0;
    req_en        = '0;
    req_addr      = '0;
    req_rdwr      = '0;
    req_data      = '0;
    dram_valid    = 1'b0;
    dram_data_out = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    tick();
    tick();
    n_vec++; if (gnt !== 4'b0) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_vec++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    n_vec++; if (dram_en !== 8'h00) begin n_err++; $display("FAIL reset_dram_en: got %h want 00", dram_en); end
    n_vec++; if (dram_rdwr !== 1'b0) begin n_err++; $display("FAIL reset_dram_rdwr: got %b want 0", dram_rdwr); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b1;
    // stray dram_valid with nothing outstanding must be dropped
    dram_valid = 1'b1;
    #1;
    n_vec++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL stray_valid: got %b want 0000", rsp_valid); end
    tick();
    dram_valid = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL stray_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_write();
    wr_t e, o;
    idle_inputs();
    obs_q.delete();
    req[0]          = 1'b1;
    req_rdwr[0]     = 1'b1;
    req_en[0]       = 8'h03;
    req_addr[0][0]  = 64'h100;
    req_data[0][0]  = 8'h96;
    req_addr[0][1]  = 64'h0FF;
    req_data[0][1]  = 8'h01;
    exp_q.push_back('{addr: 64'h100, data: 8'h96});
    exp_q.push_back('{addr: 64'h0FF, data: 8'h01});
    #1;
    n_vec++; if (gnt !== 4'b0) begin n_err++; $display("FAIL sw_gnt_early: got %b want 0000", gnt); end
    tick();
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL sw_gnt: got %b want 0001", gnt); end
    n_vec++; if (dram_en !== 8'h03) begin n_err++; $display("FAIL sw_dram_en: got %h want 03", dram_en); end
    req[0] = 1'b0;  // drop in the same cycle as the last write
    #1;
    n_vec++; if (dram_en !== 8'h03) begin n_err++; $display("FAIL sw_last_write_en: got %h want 03", dram_en); end
    tick();
    idle_inputs();
    n_vec++; if (gnt !== 4'b0) begin n_err++; $display("FAIL sw_gnt_drop: got %b want 0000", gnt); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sw_idle: got busy=%b want 0", busy); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL sw_wr_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o.addr !== e.addr || o.data !== e.data) begin
        n_err++; $display("FAIL sw_write: got %h@%h want %h@%h", o.data, o.addr, e.data, e.addr);
      end
    end
    n_vec++; if (mem[64'h100] !== 8'h96) begin n_err++; $display("FAIL sw_mem100: got %h want 96", mem[64'h100]); end
    n_vec++; if (mem[64'h0FF] !== 8'h01) begin n_err++; $display("FAIL sw_mem0ff: got %h want 01", mem[64'h0FF]); end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_fairness();
    wr_t e, o;
    int ow, waited;
    reset = 1'b0;
    idle_inputs();
    tick();
    reset = 1'b1;
    obs_q.delete();
    for (int i = 0; i < NR; i++) begin
      req_rdwr[i]    = 1'b1;
      req_en[i]      = 8'(1 << i);
      req_addr[i][i] = 64'h300 + 64'(i);
      req_data[i][i] = 8'(8'hA0 + i);
    end
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      ow = k % NR;
      waited = 0;
      while (gnt === 4'b0 && waited < 8) begin
        tick();
        waited++;
      end
      n_vec++; if (gnt !== 4'(1 << ow)) begin n_err++; $display("FAIL fair_order[%0d]: got %b want %b", k, gnt, 4'(1 << ow)); end
      n_vec++; if (waited != 1) begin n_err++; $display("FAIL fair_gap[%0d]: got %0d idle cycles want 1", k, waited); end
      #1;
      n_vec++; if (dram_en !== 8'(1 << ow)) begin n_err++; $display("FAIL fair_en[%0d]: got %h want %h", k, dram_en, 8'(1 << ow)); end
      exp_q.push_back('{addr: 64'h300 + 64'(ow), data: 8'(8'hA0 + ow)});
      exp_q.push_back('{addr: 64'h300 + 64'(ow), data: 8'(8'hA0 + ow)});
      tick();
      req[ow] = 1'b0;
      if (k == 4) req = '0;
      tick();
      n_vec++; if (gnt !== 4'b0) begin n_err++; $display("FAIL fair_release[%0d]: got %b want 0000", k, gnt); end
      if (k < 4) req[ow] = 1'b1;
    end
    idle_inputs();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL fair_idle: got busy=%b want 0", busy); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL fair_wr_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o.addr !== e.addr || o.data !== e.data) begin
        n_err++; $display("FAIL fair_write: got %h@%h want %h@%h", o.data, o.addr, e.data, e.addr);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_masking();
    wr_t e, o;
    int changed;
    idle_inputs();
    obs_q.delete();
    for (int i = 0; i < 8; i++) begin
      mem[64'h200 + 64'(i)] = 8'hEE;
      req_addr[1][i] = 64'h200 + 64'(i);
      req_data[1][i] = 8'h11;
    end
    req_en[1]      = 8'hFF;
    req_rdwr[1]    = 1'b1;
    req[2]         = 1'b1;
    req_rdwr[2]    = 1'b1;
    req_en[2]      = 8'h01;
    req_addr[2][0] = 64'h400;
    req_data[2][0] = 8'h5A;
    exp_q.push_back('{addr: 64'h400, data: 8'h5A});
    tick();
    n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL mask_gnt: got %b want 0100", gnt); end
    #1;
    n_vec++; if (dram_en !== 8'h01) begin n_err++; $display("FAIL mask_en: got %h want 01", dram_en); end
    n_vec++; if (dram_addr[0] !== 64'h400) begin n_err++; $display("FAIL mask_addr: got %h want 400", dram_addr[0]); end
    req[2] = 1'b0;
    tick();
    idle_inputs();
    changed = 0;
    for (int i = 0; i < 8; i++) if (mem[64'h200 + 64'(i)] !== 8'hEE) changed++;
    n_vec++; if (changed != 0) begin n_err++; $display("FAIL mask_mem200: got %0d bytes changed want 0", changed); end
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL mask_wr_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o.addr !== e.addr || o.data !== e.data) begin
        n_err++; $display("FAIL mask_write: got %h@%h want %h@%h", o.data, o.addr, e.data, e.addr);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_read_drain();
    lane_data_t ex;
    idle_inputs();
    exp_rsp_q.delete();
    req[1]      = 1'b1;
    req_rdwr[1] = 1'b0;
    req_en[1]   = 8'hFF;
    for (int l = 0; l < 8; l++) req_addr[1][l] = 64'h500 + 64'(l);
    tick();
    n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL rd_gnt: got %b want 0010", gnt); end
    for (int r = 0; r < 3; r++) begin
      #1;
      n_vec++; if (dram_en !== 8'hFF || dram_rdwr !== 1'b0) begin n_err++; $display("FAIL rd_issue[%0d]: got en=%h rdwr=%b want en=ff rdwr=0", r, dram_en, dram_rdwr); end
      exp_rsp_q.push_back({8{8'(8'h10 + r)}});
      if (r == 2) req[1] = 1'b0;
      tick();
    end
    req_en = '0;
    n_vec++; if (gnt !== 4'b0 || busy !== 1'b1) begin n_err++; $display("FAIL rd_drain_state: got gnt=%b busy=%b want gnt=0000 busy=1", gnt, busy); end
    n_vec++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL rd_no_rsp: got %b want 0000", rsp_valid); end
    for (int r = 0; r < 3; r++) begin
      dram_valid    = 1'b1;
      dram_data_out = {8{8'(8'h10 + r)}};
      #1;
      ex = exp_rsp_q.pop_front();
      n_vec++; if (rsp_valid !== 4'b0010) begin n_err++; $display("FAIL rd_rsp_valid[%0d]: got %b want 0010", r, rsp_valid); end
      n_vec++; if (rsp_data !== ex) begin n_err++; $display("FAIL rd_rsp_data[%0d]: got %h want %h", r, rsp_data, ex); end
      tick();
      dram_valid = 1'b0;
      n_vec++; if (busy !== (r < 2)) begin n_err++; $display("FAIL rd_busy[%0d]: got %b want %b", r, busy, (r < 2)); end
      #1;
      n_vec++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL rd_gap[%0d]: got %b want 0000", r, rsp_valid); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    int n;
    idle_inputs();
    req[3]      = 1'b1;
    req_rdwr[3] = 1'b0;
    req_en[3]   = 8'hFF;
    tick();
    n_vec++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL bp_gnt: got %b want 1000", gnt); end
    for (int r = 0; r < 6; r++) begin
      #1;
      n_vec++; if (dram_en !== ((r < 4) ? 8'hFF : 8'h00)) begin n_err++; $display("FAIL bp_en[%0d]: got %h want %h", r, dram_en, (r < 4) ? 8'hFF : 8'h00); end
      tick();
    end
    dram_valid = 1'b1;
    #1;
    n_vec++; if (rsp_valid !== 4'b1000) begin n_err++; $display("FAIL bp_rsp: got %b want 1000", rsp_valid); end
    tick();
    dram_valid = 1'b0;
    #1;
    n_vec++; if (dram_en !== 8'hFF) begin n_err++; $display("FAIL bp_resume: got %h want ff", dram_en); end
    req[3] = 1'b0;
    tick();
    req_en = '0;
    n_vec++; if (gnt !== 4'b0 || busy !== 1'b1) begin n_err++; $display("FAIL bp_drain: got gnt=%b busy=%b want 0000/1", gnt, busy); end
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      dram_valid = 1'b1;
      tick();
      n++;
    end
    dram_valid = 1'b0;
    n_vec++; if (n != 4) begin n_err++; $display("FAIL bp_drain_count: got %0d responses want 4", n); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    req[0]         = 1'b1;
    req_rdwr[0]    = 1'b1;
    req_en[0]      = 8'h01;
    req_addr[0][0] = 64'h600;
    req_data[0][0] = 8'h77;
    tick();
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL ar_gnt: got %b want 0001", gnt); end
    #2;
    reset = 1'b0;
    #1;
    n_vec++; if (gnt !== 4'b0) begin n_err++; $display("FAIL ar_gnt_clear: got %b want 0000", gnt); end
    n_vec++; if (dram_en !== 8'h00) begin n_err++; $display("FAIL ar_en_clear: got %h want 00", dram_en); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ar_busy_clear: got %b want 0", busy); end
    tick();
    idle_inputs();
    req[3] = 1'b1;
    reset  = 1'b1;
    #1;
    n_vec++; if (gnt !== 4'b0) begin n_err++; $display("FAIL ar_gnt_early: got %b want 0000", gnt); end
    tick();
    n_vec++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL ar_regrant: got %b want 1000", gnt); end
    req[3] = 1'b0;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ar_idle: got %b want 0", busy); end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fairness();
    test_masking();
    test_read_drain();
    test_backpressure();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Round-robin arbiter that shares one 8-lane DRAM port between NUM_REQ serializer engines (top_varint, fixed-width and length-delimited writers).
- A grant is held for a whole multi-cycle transaction, so each engine's writes to consecutive bytes stay contiguous.
- Read responses are routed back to the engine that issued the read.
- Sits between the engines and one port of DRAM.

Parameters:
- NUM_REQ, 4, number of requesting engines (2..8).
- MAX_OUTSTANDING, 4, maximum number of reads in flight per grant before the arbiter masks further read enables.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  engine requests ownership of the port; held high for the whole transaction
- req_en  in  NUM_REQ x 8  per-engine byte-lane enables
- req_addr  in  NUM_REQ x 8 x 64  per-lane byte addresses
- req_rdwr  in  NUM_REQ  1 = write, 0 = read
- req_data  in  NUM_REQ x 8 x 8  per-lane write bytes
- gnt  out  NUM_REQ  one-hot ownership
- rsp_valid  out  NUM_REQ  read data valid, routed to the engine that issued the read
- rsp_data  out  8 x 8  read bytes, broadcast to all engines
- dram_en  out  8  lane enables to DRAM
- dram_addr  out  8 x 64  lane addresses to DRAM
- dram_rdwr  out  1  1 = write, 0 = read
- dram_data  out  8 x 8  write bytes to DRAM
- dram_data_out  in  8 x 8  DRAM read bytes
- dram_valid  in  1  DRAM read-data valid
- busy  out  1  port owned or reads still outstanding

Behaviour:
- Reset (reset low, asynchronous): gnt=0, rsp_valid=0, dram_en=0, dram_rdwr=0, busy=0, state=IDLE, rr_ptr=0, outstanding=0.
- States: IDLE, OWN, DRAIN.
- IDLE:
  - If any req is high at a posedge, grant the first requester at or after rr_ptr (round-robin, wrapping).
  - gnt is registered: it rises on that edge. Next state is OWN.
  - Minimum latency from req to gnt is 1 cycle.
- OWN:
  - dram_* is a combinational mux of the owner's req_* bundle.
  - Non-owner bundles are ignored; their lane enables never reach DRAM.
  - When the owner's req is sampled low: gnt clears on that edge, rr_ptr = owner+1 (mod NUM_REQ).
  - Then: go to DRAIN if outstanding>0 (or a read is issued that same cycle), else IDLE.
- DRAIN:
  - dram_en=0.
  - gnt stays 0, but the response-routing owner index is retained.
  - Return to IDLE on the edge where outstanding reaches 0.
- Bus turnaround: at least one cycle with dram_en=0 between two owners; back-to-back grants cannot overlap.
- Outstanding counter:
  - +1 on each OWN cycle with dram_en!=0 and dram_rdwr=0.
  - -1 on each dram_valid.
  - A simultaneous issue and return leaves it unchanged.
- At outstanding==MAX_OUTSTANDING the arbiter forces dram_en=0 for read cycles; the engine must hold its request until the count drops.
- rsp_valid[owner] = dram_valid while outstanding>0 (combinational). A dram_valid with outstanding==0 is dropped.
- rsp_data = dram_data_out, unregistered.
- The owner may drop req in the same cycle it issues its last write; that write still reaches DRAM in that cycle.
- A req that drops before it is granted is simply not granted. No lockout: every requester is served within NUM_REQ grants.
- busy = (state != IDLE).
- Reset asserted mid-transaction: all outputs clear immediately. In-flight read responses are discarded.

Decomposition:
- Shared package: DRAM_LANES=8, ADDR_W=64, BYTE_W=8, typedef lane_addr_t [7:0][63:0], typedef lane_data_t [7:0][7:0], enum arb_state_t {IDLE, OWN, DRAIN}.
- Sub-module rr_picker: combinational round-robin priority select (req vector and rr_ptr in, one-hot grant and index out).

Test Plan:
- Single write:
  - Stimulus: only req[0] high. Engine writes bytes 96 01 at 0x100/0x0FF, then drops req.
  - Required: gnt[0] one cycle after req; mem[0x100]=96, mem[0x0FF]=01; gnt low on the drop edge; back to IDLE.
- Fairness:
  - Stimulus: req[0..3] all held high; each owner releases after 2 cycles.
  - Required: grant order 0,1,2,3,0; exactly one idle cycle between owners; no overlapping dram_en.
- Masking:
  - Stimulus: req[2] granted; req[1] drives en=8'hFF at 0x200 concurrently.
  - Required: mem[0x200..0x207] unchanged; only engine 2's lanes reach DRAM.
- Read drain:
  - Stimulus: owner 1 issues 3 reads, then drops req before any dram_valid.
  - Required: state DRAIN; rsp_valid[1] pulses 3 times; rsp_valid[0,2,3] stay 0; IDLE after the third.
- Backpressure:
  - Stimulus: MAX_OUTSTANDING=4; owner issues 6 consecutive reads with no dram_valid.
  - Required: dram_en=0 from the 5th read onward until a dram_valid arrives.
- Async reset:
  - Stimulus: reset asserted low mid-OWN, between clock edges.
  - Required: gnt, dram_en, busy go to 0 immediately; after release req[3] alone gets the grant 1 cycle later.
